// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

   // Default geometry: 16 lines of 32 bytes (8 words) each.
   localparam int LINES_DEF = 16;
   localparam int OFFSET_W  = 5;
   localparam int INDEX_W   = $clog2(LINES_DEF);
   localparam int TAG_W     = 32 - OFFSET_W - INDEX_W;
   localparam int LINE_W    = 256;
   localparam int WORDS     = 8;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } state_e;

   // Pick 32-bit word `sel` out of a line; word w lives in bits [32w+31:32w].
   function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                             input logic [2:0]        sel);
      return line[{sel, 5'b00000} +: 32];
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
//
// Memory handshake: mem_req_o rises with mem_we_o/mem_addr_o/mem_wdata_o
// already valid and all four hold constant until the cycle in which the
// memory returns a single-cycle mem_ack_i pulse (mem_rdata_i valid in that
// same cycle for fills). mem_ack_i is meaningless while mem_req_o = 0.
// CPU side: while cpu_stall_o = 1 the CPU holds cpu_req_i/we/addr/wdata.
interface dcache_if;
   import dcache_pkg::*;

   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [31:0]       cpu_addr_i;
   logic [31:0]       cpu_wdata_i;
   logic [31:0]       cpu_rdata_o;
   logic              cpu_stall_o;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [31:0]       mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic [LINE_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   // Cache side.
   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output cpu_rdata_o, cpu_stall_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   // CPU + backing-memory side.
   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_rdata_o, cpu_stall_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line-data storage: combinational read at one index,
// synchronous whole-line fill and single-word store.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int LINES = LINES_DEF,
   parameter int IDX_W = $clog2(LINES),
   parameter int TG_W  = 32 - OFFSET_W - IDX_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [TG_W-1:0]   rd_tag_o,
   output logic [LINE_W-1:0] rd_line_o,
   input  logic              line_we_i,
   input  logic [TG_W-1:0]   line_tag_i,
   input  logic [LINE_W-1:0] line_data_i,
   input  logic              word_we_i,
   input  logic [2:0]        word_sel_i,
   input  logic [31:0]       word_data_i,
   input  logic              dirty_clr_i
);

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;
   logic [TG_W-1:0]   tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   // Combinational read of the addressed line.
   always_comb begin
      rd_valid_o = valid_q[idx_i];
      rd_dirty_o = dirty_q[idx_i];
      rd_tag_o   = tag_q[idx_i];
      rd_line_o  = data_q[idx_i];
   end

   // Valid/dirty bits: cleared by reset; a fill makes a line clean, a store dirties it.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
         end
         if (dirty_clr_i) begin
            dirty_q[idx_i] <= 1'b0;
         end
         if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
         end
      end
   end

   // Tag and data arrays are not reset; valid bits guard their contents.
   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         tag_q[idx_i]  <= line_tag_i;
         data_q[idx_i] <= line_data_i;
      end else if (word_we_i) begin
         data_q[idx_i][{word_sel_i, 5'b00000} +: 32] <= word_data_i;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller: hit logic,
// miss FSM (IDLE -> [WRITE_BACK] -> ALLOCATE -> IDLE) and output muxing.
// A stalled request is simply re-looked-up in IDLE after the fill, so a
// pending store lands through the normal store-hit path.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int LINES = LINES_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   dcache_if.slave    bus,
   output logic [1:0] state_o
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TG_W  = 32 - OFFSET_W - IDX_W;

   localparam logic [1:0] ST_IDLE       = IDLE;
   localparam logic [1:0] ST_WRITE_BACK = WRITE_BACK;
   localparam logic [1:0] ST_ALLOCATE   = ALLOCATE;

   logic [1:0]        state_q;
   logic [1:0]        state_d;

   logic [IDX_W-1:0]  idx;
   logic [TG_W-1:0]   req_tag;
   logic [2:0]        wsel;
   logic [1:0]        unused_addr_lsb;

   logic              rd_valid;
   logic              rd_dirty;
   logic [TG_W-1:0]   rd_tag;
   logic [LINE_W-1:0] rd_line;
   logic              hit;

   logic              line_we;
   logic              word_we;
   logic              dirty_clr;

   logic              stall;
   logic [31:0]       rdata;
   logic              mem_req;
   logic              mem_we;
   logic [31:0]       mem_addr;
   logic [LINE_W-1:0] mem_wdata;

   assign idx             = bus.cpu_addr_i[OFFSET_W +: IDX_W];
   assign req_tag         = bus.cpu_addr_i[31 -: TG_W];
   assign wsel            = bus.cpu_addr_i[4:2];
   assign unused_addr_lsb = bus.cpu_addr_i[1:0];

   dcache_sram #(
      .LINES (LINES),
      .IDX_W (IDX_W),
      .TG_W  (TG_W)
   ) u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_line_o   (rd_line),
      .line_we_i   (line_we),
      .line_tag_i  (req_tag),
      .line_data_i (bus.mem_rdata_i),
      .word_we_i   (word_we),
      .word_sel_i  (wsel),
      .word_data_i (bus.cpu_wdata_i),
      .dirty_clr_i (dirty_clr)
   );

   assign hit = bus.cpu_req_i & rd_valid & (rd_tag == req_tag);

   // State register; reset abandons any memory transaction in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, array write enables and all outputs; everything is held at 0 in reset.
   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      rdata     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      line_we   = 1'b0;
      word_we   = 1'b0;
      dirty_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cpu_req_i) begin
               if (hit) begin
                  rdata   = line_word(rd_line, wsel);
                  word_we = bus.cpu_we_i;
               end else begin
                  stall   = 1'b1;
                  state_d = (rd_valid & rd_dirty) ? ST_WRITE_BACK : ST_ALLOCATE;
               end
            end
         end
         ST_WRITE_BACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {rd_tag, idx, 5'b00000};
            mem_wdata = rd_line;
            if (bus.mem_ack_i) begin
               dirty_clr = 1'b1;
               state_d   = ST_ALLOCATE;
            end
         end
         ST_ALLOCATE: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {req_tag, idx, 5'b00000};
            if (bus.mem_ack_i) begin
               line_we = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (!rst_i) begin
         stall     = 1'b0;
         rdata     = '0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         line_we   = 1'b0;
         word_we   = 1'b0;
         dirty_clr = 1'b0;
      end
   end

   assign bus.cpu_stall_o = stall;
   assign bus.cpu_rdata_o = rdata;
   assign bus.mem_req_o   = mem_req;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;
   assign state_o         = rst_i ? state_q : 2'b00;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: CPU driver task, auto-acking backing memory
// model, CPU-view reference memory feeding an expected-load-data queue.
module tb_dcache_controller;
   import dcache_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dcache_if   bus_if ();
   logic [1:0] state_o;

   dcache_controller #(.LINES(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .bus     (bus_if),
      .state_o (state_o)
   );

   // ---------------- bookkeeping ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] exp_q[$];

   typedef struct packed {
      logic          we;
      logic [31:0]   addr;
      logic [255:0]  wdata;
   } txn_t;

   txn_t obs_q[$];
   txn_t cur_txn;
   txn_t rsp_t;
   logic [255:0] rsp_line;
   int  stab_err = 0;
   bit  auto_mem = 1'b0;
   int  ack_dly  = 3;
   int  cnt      = 0;

   // Word-addressed backing memory and CPU-visible reference memory.
   logic [31:0] bk   [logic [31:0]];
   logic [31:0] refm [logic [31:0]];

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] bk_rd(input logic [31:0] a);
      if (bk.exists(a >> 2)) return bk[a >> 2];
      return pat(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (refm.exists(a >> 2)) return refm[a >> 2];
      return pat(a);
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_rd({a[31:5], 5'b0} + 32'(4*w));
      return l;
   endfunction

   // ---------------- backing memory responder ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!auto_mem) begin
            cnt = 0;
         end else begin
            if (bus_if.mem_ack_i) bus_if.mem_ack_i = 1'b0;
            if (bus_if.mem_req_o === 1'b1) begin
               rsp_t.we    = bus_if.mem_we_o;
               rsp_t.addr  = bus_if.mem_addr_o;
               rsp_t.wdata = bus_if.mem_wdata_o;
               if (cnt == 0) begin
                  cur_txn = rsp_t;
                  obs_q.push_back(rsp_t);
               end else if (rsp_t !== cur_txn) begin
                  stab_err++;
               end
               cnt++;
               if (cnt >= ack_dly) begin
                  if (rsp_t.we) begin
                     for (int w = 0; w < 8; w++)
                        bk[(rsp_t.addr >> 2) + 32'(w)] = rsp_t.wdata[32*w +: 32];
                  end else begin
                     for (int w = 0; w < 8; w++)
                        rsp_line[32*w +: 32] = bk_rd(rsp_t.addr + 32'(4*w));
                     bus_if.mem_rdata_i = rsp_line;
                  end
                  bus_if.mem_ack_i = 1'b1;
                  cnt = 0;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output int stalls, output logic [31:0] rd);
      @(negedge clk);
      bus_if.cpu_req_i   = 1'b1;
      bus_if.cpu_we_i    = we;
      bus_if.cpu_addr_i  = addr;
      bus_if.cpu_wdata_i = wd;
      #1;
      stalls = 0;
      while (bus_if.cpu_stall_o !== 1'b0 && stalls < 300) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      if (stalls >= 300) begin
         n_total++;
         n_bad++;
         $display("FAIL access_timeout addr=%h stall never dropped", addr);
      end
      rd = bus_if.cpu_rdata_o;
      if (we) refm[addr >> 2] = wd;
   endtask

   task automatic cpu_idle();
      @(negedge clk);
      bus_if.cpu_req_i = 1'b0;
      bus_if.cpu_we_i  = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      auto_mem = 1'b0;
      bus_if.mem_ack_i   = 1'b0;
      bus_if.mem_rdata_i = '0;
      bus_if.cpu_req_i   = 1'b1;
      bus_if.cpu_we_i    = 1'b0;
      bus_if.cpu_addr_i  = 32'h40;
      bus_if.cpu_wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      n_total++; if (bus_if.cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", bus_if.cpu_stall_o); end
      n_total++; if (bus_if.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got=%b exp=0", bus_if.mem_req_o); end
      n_total++; if (bus_if.cpu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", bus_if.cpu_rdata_o); end
      n_total++; if (state_o !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
      n_total++; if (bus_if.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr got=%h exp=0", bus_if.mem_addr_o); end
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.cpu_req_i = 1'b0;
      #1;
      n_total++; if (bus_if.cpu_stall_o !== 1'b0) begin n_bad++; $display("FAIL idle_stall got=%b exp=0", bus_if.cpu_stall_o); end
      n_total++; if (bus_if.cpu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL idle_rdata got=%h exp=0", bus_if.cpu_rdata_o); end
   endtask

   task automatic test_clean_miss();
      int st; logic [31:0] rd, e;
      obs_q.delete();
      stab_err = 0;
      auto_mem = 1'b1;
      ack_dly  = 3;
      exp_q.push_back(ref_rd(32'h40));
      cpu_access(1'b0, 32'h40, 32'h0, st, rd);
      e = exp_q.pop_front();
      n_total++; if (rd !== e) begin n_bad++; $display("FAIL miss_rdata got=%h exp=%h", rd, e); end
      n_total++; if (st !== 4) begin n_bad++; $display("FAIL miss_stall got=%0d exp=4", st); end
      n_total++;
      if (obs_q.size() !== 1) begin n_bad++; $display("FAIL miss_txn_count got=%0d exp=1", obs_q.size()); end
      else if (obs_q[0].we !== 1'b0 || obs_q[0].addr !== 32'h40) begin
         n_bad++; $display("FAIL miss_txn got we=%b addr=%h exp we=0 addr=00000040", obs_q[0].we, obs_q[0].addr);
      end
      n_total++; if (stab_err !== 0) begin n_bad++; $display("FAIL miss_req_stable got=%0d exp=0", stab_err); end
   endtask

   task automatic test_store_hit();
      int st; logic [31:0] rd, e;
      obs_q.delete();
      cpu_access(1'b1, 32'h44, 32'h1234_5678, st, rd);
      n_total++; if (st !== 0) begin n_bad++; $display("FAIL sthit_stall got=%0d exp=0", st); end
      exp_q.push_back(ref_rd(32'h44));
      cpu_access(1'b0, 32'h44, 32'h0, st, rd);
      e = exp_q.pop_front();
      n_total++; if (st !== 0) begin n_bad++; $display("FAIL ldhit_stall got=%0d exp=0", st); end
      n_total++; if (rd !== e) begin n_bad++; $display("FAIL ldhit_rdata got=%h exp=%h", rd, e); end
      n_total++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL hit_mem_txn got=%0d exp=0", obs_q.size()); end
   endtask

   task automatic test_dirty_evict();
      int st; logic [31:0] rd, e; logic [255:0] el;
      obs_q.delete();
      stab_err = 0;
      el = ref_line(32'h40);
      exp_q.push_back(ref_rd(32'h240));
      cpu_access(1'b0, 32'h240, 32'h0, st, rd);
      e = exp_q.pop_front();
      n_total++; if (st !== 7) begin n_bad++; $display("FAIL evict_stall got=%0d exp=7", st); end
      n_total++; if (rd !== e) begin n_bad++; $display("FAIL evict_rdata got=%h exp=%h", rd, e); end
      n_total++;
      if (obs_q.size() !== 2) begin n_bad++; $display("FAIL evict_txn_count got=%0d exp=2", obs_q.size()); end
      else begin
         if (obs_q[0].we !== 1'b1 || obs_q[0].addr !== 32'h40 || obs_q[0].wdata[63:32] !== 32'h1234_5678) begin
            n_bad++; $display("FAIL evict_wb got we=%b addr=%h w1=%h exp we=1 addr=00000040 w1=12345678",
                              obs_q[0].we, obs_q[0].addr, obs_q[0].wdata[63:32]);
         end
         n_total++;
         if (obs_q[0].wdata !== el) begin n_bad++; $display("FAIL evict_wb_line got=%h exp=%h", obs_q[0].wdata, el); end
         n_total++;
         if (obs_q[1].we !== 1'b0 || obs_q[1].addr !== 32'h240) begin
            n_bad++; $display("FAIL evict_fill got we=%b addr=%h exp we=0 addr=00000240", obs_q[1].we, obs_q[1].addr);
         end
      end
      n_total++; if (stab_err !== 0) begin n_bad++; $display("FAIL evict_req_stable got=%0d exp=0", stab_err); end
   endtask

   task automatic test_store_miss();
      int st; logic [31:0] rd, v;
      obs_q.delete();
      v = $urandom;
      cpu_access(1'b1, 32'h80, v, st, rd);
      n_total++; if (st !== 4) begin n_bad++; $display("FAIL stmiss_stall got=%0d exp=4", st); end
      n_total++;
      if (obs_q.size() !== 1) begin n_bad++; $display("FAIL stmiss_txn_count got=%0d exp=1", obs_q.size()); end
      else if (obs_q[0].we !== 1'b0 || obs_q[0].addr !== 32'h80) begin
         n_bad++; $display("FAIL stmiss_fill got we=%b addr=%h exp we=0 addr=00000080", obs_q[0].we, obs_q[0].addr);
      end
      cpu_access(1'b0, 32'h80, 32'h0, st, rd);
      n_total++; if (st !== 0 || rd !== v) begin n_bad++; $display("FAIL stmiss_readback got=%h st=%0d exp=%h st=0", rd, st, v); end
      obs_q.delete();
      cpu_access(1'b0, 32'h480, 32'h0, st, rd);
      n_total++; if (st !== 7) begin n_bad++; $display("FAIL stmiss_dirty_stall got=%0d exp=7", st); end
      n_total++;
      if (obs_q.size() !== 2) begin n_bad++; $display("FAIL stmiss_evict_count got=%0d exp=2", obs_q.size()); end
      else if (obs_q[0].we !== 1'b1 || obs_q[0].addr !== 32'h80 || obs_q[0].wdata[31:0] !== v) begin
         n_bad++; $display("FAIL stmiss_wb got we=%b addr=%h w0=%h exp we=1 addr=00000080 w0=%h",
                           obs_q[0].we, obs_q[0].addr, obs_q[0].wdata[31:0], v);
      end
   endtask

   task automatic test_ack_idle_reset();
      int st; logic [31:0] rd, e;
      cpu_access(1'b0, 32'h40, 32'h0, st, rd);
      n_total++; if (st !== 4) begin n_bad++; $display("FAIL reload_stall got=%0d exp=4", st); end
      cpu_idle();
      auto_mem = 1'b0;
      bus_if.mem_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_total++;
         if (state_o !== 2'd0 || bus_if.mem_req_o !== 1'b0) begin
            n_bad++; $display("FAIL stray_ack state=%0d req=%b exp state=0 req=0", state_o, bus_if.mem_req_o);
         end
      end
      @(negedge clk);
      bus_if.mem_ack_i  = 1'b0;
      bus_if.cpu_req_i  = 1'b1;
      bus_if.cpu_we_i   = 1'b0;
      bus_if.cpu_addr_i = 32'h1000;
      #1;
      n_total++; if (bus_if.cpu_stall_o !== 1'b1) begin n_bad++; $display("FAIL abort_detect got=%b exp=1", bus_if.cpu_stall_o); end
      @(negedge clk);
      #1;
      n_total++;
      if (state_o !== 2'd2 || bus_if.mem_req_o !== 1'b1 || bus_if.mem_addr_o !== 32'h1000) begin
         n_bad++; $display("FAIL abort_alloc state=%0d req=%b addr=%h exp 2 1 00001000", state_o, bus_if.mem_req_o, bus_if.mem_addr_o);
      end
      rst_n = 1'b0;
      bus_if.cpu_req_i = 1'b0;
      @(negedge clk);
      #1;
      n_total++; if (bus_if.mem_req_o !== 1'b0) begin n_bad++; $display("FAIL abort_req_drop got=%b exp=0", bus_if.mem_req_o); end
      @(negedge clk);
      rst_n = 1'b1;
      auto_mem = 1'b1;
      obs_q.delete();
      exp_q.push_back(ref_rd(32'h40));
      cpu_access(1'b0, 32'h40, 32'h0, st, rd);
      e = exp_q.pop_front();
      n_total++; if (st !== 4) begin n_bad++; $display("FAIL post_rst_miss_stall got=%0d exp=4", st); end
      n_total++; if (rd !== e) begin n_bad++; $display("FAIL post_rst_rdata got=%h exp=%h", rd, e); end
      n_total++;
      if (obs_q.size() !== 1 || obs_q[0].addr !== 32'h40) begin
         n_bad++; $display("FAIL post_rst_fill count=%0d exp one fill at 00000040", obs_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int st; logic [31:0] rd, e, a, v;
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         a = 32'h40 + 32'(4 * (i >> 1));
         if ((i % 2) == 0) begin
            v = $urandom_range(32'hFFFF_FFFF, 0);
            cpu_access(1'b1, a, v, st, rd);
         end else begin
            exp_q.push_back(ref_rd(a));
            cpu_access(1'b0, a, 32'h0, st, rd);
            e = exp_q.pop_front();
            n_total++; if (rd !== e) begin n_bad++; $display("FAIL b2b_rdata addr=%h got=%h exp=%h", a, rd, e); end
         end
         n_total++; if (st !== 0) begin n_bad++; $display("FAIL b2b_stall addr=%h got=%0d exp=0", a, st); end
      end
      n_total++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL b2b_mem_txn got=%0d exp=0", obs_q.size()); end
      cpu_idle();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      bk[32'h40 >> 2]   = 32'hDEAD_BEEF;
      refm[32'h40 >> 2] = 32'hDEAD_BEEF;
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_dirty_evict();
      test_store_miss();
      test_ack_idle_reset();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
